// File: rtl/rom_arb_pkg.sv
// rtl/rom_arb_pkg.sv - shared types and constants for the ROM read arbiter
package rom_arb_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } arb_state_t;

  localparam int ROM_ADDR_W = 4;
  localparam int ROM_DATA_W = 32;
  localparam int STATS_W    = 16;

endpackage

// File: rtl/rom_read_arbiter_if.sv
// rtl/rom_read_arbiter_if.sv - requester-side request/response bundle of the ROM read arbiter
interface rom_read_arbiter_if
  import rom_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = ROM_ADDR_W,
  parameter int DATA_W  = ROM_DATA_W
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        resp_valid;
  logic [NUM_REQ*DATA_W-1:0] resp_data;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  resp_valid,
    input  resp_data
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output resp_valid,
    output resp_data
  );

endinterface

// File: rtl/rom_read_arbiter_rr_pick.sv
// rtl/rom_read_arbiter_rr_pick.sv - rotate-and-find-first picker used for each ROM port
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] start,
  input  logic [N-1:0]  mask,
  output logic [PW-1:0] idx,
  output logic          found
);

  always_comb begin
    int j;
    j     = 0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(start) + k;
      if (j >= N) j = j - N;
      if (!found && valid[j] && !mask[j]) begin
        found = 1'b1;
        idx   = PW'(j);
      end
    end
  end

endmodule

// File: rtl/rom_read_arbiter.sv
// rtl/rom_read_arbiter.sv - two-port round-robin arbiter in front of the dual-read 16x32 ROM
// Optional per-requester grant counters: define ROM_ARB_STATS_EN.
module rom_read_arbiter
  import rom_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = ROM_ADDR_W,
  parameter int DATA_W      = ROM_DATA_W,
  parameter int INIT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  rom_read_arbiter_if.slave bus,
  output logic [ADDR_W-1:0] rom_dir1,
  output logic [ADDR_W-1:0] rom_dir2,
  input  logic [DATA_W-1:0] rom_dato1,
  input  logic [DATA_W-1:0] rom_dato2,
  output logic              init_done
`ifdef ROM_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STATS_W-1:0] grant_cnt
`endif
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(INIT_CYCLES + 1);

  arb_state_t state, state_nxt;
  logic [CW-1:0]             init_cnt;
  logic [PW-1:0]             rr_ptr, rr_nxt;
  logic [NUM_REQ-1:0]        gnt1, gnt2, grant;
  logic [NUM_REQ-1:0]        mask2;
  logic [PW-1:0]             idx1, idx2;
  logic                      found1, found2;
  logic [NUM_REQ-1:0]        resp_valid_q;
  logic [NUM_REQ*DATA_W-1:0] resp_data_q;

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
    return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick1 (
    .valid (bus.req_valid),
    .start (rr_ptr),
    .mask  ('0),
    .idx   (idx1),
    .found (found1)
  );

  // Port 2 continues the same scan with the port-1 winner removed.
  assign mask2 = found1 ? (NUM_REQ'(1) << idx1) : '0;

  rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick2 (
    .valid (bus.req_valid),
    .start (rr_ptr),
    .mask  (mask2),
    .idx   (idx2),
    .found (found2)
  );

  always_comb begin
    state_nxt = state;
    gnt1      = '0;
    gnt2      = '0;
    rom_dir1  = '0;
    rom_dir2  = '0;
    rr_nxt    = rr_ptr;
    case (state)
      ST_INIT: begin
        if (init_cnt == CW'(INIT_CYCLES - 1)) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (found1) begin
          gnt1[idx1] = 1'b1;
          rom_dir1   = bus.req_addr[idx1*ADDR_W +: ADDR_W];
          rr_nxt     = next_idx(idx1);
        end
        if (found2) begin
          gnt2[idx2] = 1'b1;
          rom_dir2   = bus.req_addr[idx2*ADDR_W +: ADDR_W];
          rr_nxt     = next_idx(idx2);
        end
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  assign grant         = gnt1 | gnt2;
  assign bus.req_ready = grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_INIT;
      init_cnt     <= '0;
      rr_ptr       <= '0;
      init_done    <= 1'b0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_nxt;
      init_done <= (state_nxt == ST_RUN);
      if (state == ST_INIT) init_cnt <= init_cnt + 1'b1;
      // No response backpressure: every valid bit lasts exactly one cycle.
      resp_valid_q <= grant;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt1[i])      resp_data_q[i*DATA_W +: DATA_W] <= rom_dato1;
        else if (gnt2[i]) resp_data_q[i*DATA_W +: DATA_W] <= rom_dato2;
      end
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;

`ifdef ROM_ARB_STATS_EN
  logic [STATS_W-1:0] cnt_q [NUM_REQ];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) grant_cnt[i*STATS_W +: STATS_W] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_rom_read_arbiter.sv
// tb/tb_rom_read_arbiter.sv - directed self-checking bench for rom_read_arbiter
module tb_rom_read_arbiter;
  import rom_arb_pkg::*;

  logic        clk;
  logic        rst;
  logic [3:0]  rom_dir1, rom_dir2;
  logic [31:0] rom_dato1, rom_dato2;
  logic        init_done;
`ifdef ROM_ARB_STATS_EN
  logic [63:0] grant_cnt;
`endif

  int n_cmp;
  int n_err;

  rom_read_arbiter_if #(.NUM_REQ(4), .ADDR_W(4), .DATA_W(32)) bus ();

  rom_read_arbiter #(.NUM_REQ(4), .ADDR_W(4), .DATA_W(32), .INIT_CYCLES(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .rom_dir1  (rom_dir1),
    .rom_dir2  (rom_dir2),
    .rom_dato1 (rom_dato1),
    .rom_dato2 (rom_dato2),
    .init_done (init_done)
`ifdef ROM_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  // ROM image: word at address a is 32'hC0DE000a.
  assign rom_dato1 = {16'hC0DE, 12'h000, rom_dir1};
  assign rom_dato2 = {16'hC0DE, 12'h000, rom_dir2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    bus.req_valid = 4'b1111;
    bus.req_addr  = {4'd4, 4'd3, 4'd2, 4'd1};
    #23;
    expect_eq("reset_init_done", init_done, 1'b0);
    expect_eq("reset_resp_valid", bus.resp_valid, 4'b0000);
    expect_eq("reset_resp_data", bus.resp_data[63:0], 64'h0);

    // 1) INIT window: no grants for 16 cycles, init_done on the 16th edge
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int c = 0; c < 16; c++) begin
      expect_eq($sformatf("init_ready_c%0d", c), bus.req_ready, 4'b0000);
      expect_eq($sformatf("init_done_c%0d", c), init_done, 1'b0);
      step();
    end
    expect_eq("init_done_rise", init_done, 1'b1);
    bus.req_valid = 4'b0000;
    #1;
    expect_eq("idle_ready", bus.req_ready, 4'b0000);
    expect_eq("idle_dir1", rom_dir1, 4'd0);

    // 2) single requester 2 at address 5
    bus.req_valid = 4'b0100;
    bus.req_addr  = {4'd0, 4'd5, 4'd0, 4'd0};
    #1;
    expect_eq("t2_dir1", rom_dir1, 4'd5);
    expect_eq("t2_dir2", rom_dir2, 4'd0);
    expect_eq("t2_ready", bus.req_ready, 4'b0100);
    step();
    bus.req_valid = 4'b0000;
    expect_eq("t2_resp_valid", bus.resp_valid, 4'b0100);
    expect_eq("t2_resp_data2", bus.resp_data[64 +: 32], 32'hC0DE0005);

    // bring rr_ptr back to 0 with a lone grant to requester 3
    bus.req_valid = 4'b1000;
    bus.req_addr  = {4'd7, 4'd0, 4'd0, 4'd0};
    #1;
    expect_eq("t3pre_ready", bus.req_ready, 4'b1000);
    step();
    expect_eq("t3pre_resp_data3", bus.resp_data[96 +: 32], 32'hC0DE0007);

    // 3) all valid from rr_ptr=0: {0,1}, {2,3}, {0,1}
    bus.req_valid = 4'b1111;
    bus.req_addr  = {4'd4, 4'd3, 4'd2, 4'd1};
    #1;
    expect_eq("t3_ready_a", bus.req_ready, 4'b0011);
    expect_eq("t3_dir1_a", rom_dir1, 4'd1);
    expect_eq("t3_dir2_a", rom_dir2, 4'd2);
    step();
    expect_eq("t3_resp_valid_a", bus.resp_valid, 4'b0011);
    expect_eq("t3_resp_data0", bus.resp_data[0 +: 32], 32'hC0DE0001);
    expect_eq("t3_resp_data1", bus.resp_data[32 +: 32], 32'hC0DE0002);
    expect_eq("t3_ready_b", bus.req_ready, 4'b1100);
    expect_eq("t3_dir1_b", rom_dir1, 4'd3);
    expect_eq("t3_dir2_b", rom_dir2, 4'd4);
    step();
    expect_eq("t3_resp_valid_b", bus.resp_valid, 4'b1100);
    expect_eq("t3_resp_data3", bus.resp_data[96 +: 32], 32'hC0DE0004);
    expect_eq("t3_ready_c", bus.req_ready, 4'b0011);
    step();
    bus.req_valid = 4'b0000;
    expect_eq("t3_resp_valid_c", bus.resp_valid, 4'b0011);
    step();
    expect_eq("t3_resp_valid_idle", bus.resp_valid, 4'b0000);

    // 4) rr_ptr=2, requesters 1 and 3 both at address 9
    bus.req_valid = 4'b1010;
    bus.req_addr  = {4'd9, 4'd0, 4'd9, 4'd0};
    #1;
    expect_eq("t4_ready", bus.req_ready, 4'b1010);
    expect_eq("t4_dir1", rom_dir1, 4'd9);
    expect_eq("t4_dir2", rom_dir2, 4'd9);
    step();
    bus.req_valid = 4'b0000;
    expect_eq("t4_resp_valid", bus.resp_valid, 4'b1010);
    expect_eq("t4_resp_data1", bus.resp_data[32 +: 32], 32'hC0DE0009);
    expect_eq("t4_resp_data3", bus.resp_data[96 +: 32], 32'hC0DE0009);
    expect_eq("t4_hold_data0", bus.resp_data[0 +: 32], 32'hC0DE0001);

    // 5) reset lands while a grant is being offered
    @(negedge clk);
    bus.req_valid = 4'b0001;
    bus.req_addr  = {4'd0, 4'd0, 4'd0, 4'd6};
    #1;
    expect_eq("t5_ready_pre", bus.req_ready, 4'b0001);
    rst = 1'b1;
    #1;
    expect_eq("t5_ready_rst", bus.req_ready, 4'b0000);
    step();
    expect_eq("t5_resp_valid", bus.resp_valid, 4'b0000);
    expect_eq("t5_init_done", init_done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int c = 0; c < 15; c++) step();
    expect_eq("t5_init_c15", init_done, 1'b0);
    expect_eq("t5_resp_valid_init", bus.resp_valid, 4'b0000);
    step();
    expect_eq("t5_init_c16", init_done, 1'b1);
    expect_eq("t5_ready_run", bus.req_ready, 4'b0001);

`ifdef ROM_ARB_STATS_EN
    // 6) saturate requester 0's grant counter
    for (int c = 0; c < 70000; c++) step();
    expect_eq("t6_cnt0", grant_cnt[15:0], 16'hFFFF);
    expect_eq("t6_cnt_others", grant_cnt[63:16], 48'h0);
`endif
    bus.req_valid = 4'b0000;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
